// File: rtl/seq_mult_ctrl.sv
// Repeated-addition unsigned multiplier with its own load/compute/done control FSM.
// Define MULT_OPSWAP_EN to swap operands in LDB so the loop runs min(A,B) times.
module seq_mult_ctrl #(
    parameter int W  = 16,
    parameter int PW = 2 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  data_in,
    input  logic          data_vld,
    output logic          data_rdy,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] product,
    output logic          eqz
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LDA  = 3'd1;
    localparam logic [2:0] ST_LDB  = 3'd2;
    localparam logic [2:0] ST_CALC = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [PW-1:0] p_q, p_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    p_d     = '0;
                    state_d = ST_LDA;
                end
            end
            ST_LDA: begin
                if (data_vld) begin
                    a_d     = data_in;
                    state_d = ST_LDB;
                end
            end
            ST_LDB: begin
                if (data_vld) begin
`ifdef MULT_OPSWAP_EN
                    // Keep the smaller operand as the loop count.
                    if (data_in > a_q) begin
                        a_d = data_in;
                        b_d = a_q;
                    end else begin
                        b_d = data_in;
                    end
`else
                    b_d = data_in;
`endif
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (b_q != '0) begin
                    p_d = p_q + {{(PW-W){1'b0}}, a_q};
                    b_d = b_q - {{(W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data_rdy = (state_q == ST_LDA) || (state_q == ST_LDB);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign product  = p_q;
    assign eqz      = (b_q == '0);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: stimulus pushes expected product and done cycle,
// a negedge monitor pops and compares whenever done pulses.
module tb_seq_mult_ctrl;

    localparam int W  = 16;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  data_in;
    logic          data_vld;
    logic          data_rdy;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;
    logic          eqz;

    typedef struct {
        logic [PW-1:0] prod;
        int            doneCyc;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cycleCnt = 0;

    seq_mult_ctrl #(.W(W), .PW(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .data_vld (data_vld),
        .data_rdy (data_rdy),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .eqz      (eqz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int iterModel(input int a, input int b);
`ifdef MULT_OPSWAP_EN
        return (a < b) ? a : b;
`else
        return b;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("product", 64'(product), 64'(e.prod));
                checkOutput("done_cycle", 64'(cycleCnt), 64'(e.doneCyc));
            end
        end
    end

    // One multiply; abortAt>0 resets on that CALC cycle instead of finishing.
    task automatic applyStimulus(input int a, input int b, input int gapA, input int gapB,
                                 input bit junk, input int abortAt);
        int   iter;
        int   acceptCyc;
        int   limit;
        bit   seen;
        exp_t e;
        iter = iterModel(a, b);
        @(negedge clk);
        start    = 1'b1;
        data_vld = 1'b1;
        data_in  = W'($urandom);
        @(negedge clk);
        start     = 1'b0;
        data_vld  = 1'b0;
        acceptCyc = cycleCnt;
        checkOutput("cleared_on_start", 64'(product), 64'd0);
        checkOutput("busy_in_lda", 64'(busy), 64'd1);
        if (abortAt == 0) begin
            e.prod    = PW'(a) * PW'(b);
            e.doneCyc = acceptCyc + gapA + gapB + iter + 3;
            expQ.push_back(e);
        end
        for (int i = 0; i < gapA; i++) begin
            checkOutput("rdy_during_stall", 64'(data_rdy), 64'd1);
            @(negedge clk);
        end
        data_vld = 1'b1;
        data_in  = W'(a);
        @(negedge clk);
        data_vld = 1'b0;
        data_in  = W'($urandom);
        for (int i = 0; i < gapB; i++) @(negedge clk);
        data_vld = 1'b1;
        data_in  = W'(b);
        @(negedge clk);
        data_vld = 1'b0;
        checkOutput("eqz_first_calc", 64'(eqz), 64'(iter == 0));
        checkOutput("rdy_in_calc", 64'(data_rdy), 64'd0);
        if (abortAt > 0) begin
            repeat (abortAt - 1) @(negedge clk);
            checkOutput("partial_product", 64'(product), 64'(a * (abortAt - 1)));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checkOutput("abort_product", 64'(product), 64'd0);
            checkOutput("abort_busy", 64'(busy), 64'd0);
            checkOutput("abort_eqz", 64'(eqz), 64'd1);
            checkOutput("abort_rdy", 64'(data_rdy), 64'd0);
        end else begin
            limit = iter + 10;
            seen  = 1'b0;
            for (int i = 0; i < limit && !seen; i++) begin
                if (junk) begin
                    start    = 1'($urandom);
                    data_vld = 1'($urandom);
                    data_in  = W'($urandom);
                end
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            start    = 1'b0;
            data_vld = 1'b0;
            if (!seen) begin
                checkOutput("done_timeout", 64'd0, 64'd1);
                expQ.delete();
            end
        end
    endtask

    initial begin
        int a, b;
        logic [PW-1:0] held;
        rst      = 1'b1;
        start    = 1'b0;
        data_vld = 1'b0;
        data_in  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rdy", 64'(data_rdy), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_product", 64'(product), 64'd0);
        checkOutput("rst_eqz", 64'(eqz), 64'd1);
        rst = 1'b0;

        applyStimulus(3, 5, 0, 0, 1'b0, 0);
        applyStimulus(7, 0, 0, 0, 1'b0, 0);
        applyStimulus(0, 9, 1, 0, 1'b0, 0);
        applyStimulus(255, 255, 0, 0, 1'b0, 0);
        applyStimulus(2, 100, 0, 0, 1'b0, 10);
        applyStimulus(4, 4, 0, 0, 1'b0, 0);
        applyStimulus(6, 11, 2, 0, 1'b1, 0);

        // Product must hold through idle time, then clear on the next start.
        held = PW'(6 * 11);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_product", 64'(product), 64'(held));
            checkOutput("hold_busy", 64'(busy), 64'd0);
            @(negedge clk);
        end

        for (int n = 0; n < 20; n++) begin
            a = int'($urandom_range(0, 60));
            b = int'($urandom_range(0, 60));
            applyStimulus(a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'($urandom), 0);
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
